// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 VGA timing constants and the DAC colour type
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int CLK_DIV  = 2;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Scan counters are 10 bits; both totals must stay at or below 1024.
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/pixel_strobe.sv
// rtl/pixel_strobe.sv - clk divider producing the pixel strobe and DAC pixel clock
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-low reset
//   pix_en  out  one-clk strobe on the last clk of each pixel period
//   vga_clk out  pixel clock, low for the first CLK_DIV/2 clks of each period
module pixel_strobe #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en,
    output logic vga_clk
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div_cnt + 1'b1;
        if (div_cnt == DIV_LAST) begin
            div_next = '0;
        end
    end

    assign pix_en = (div_cnt == DIV_LAST);

    // vga_clk is registered from the next count so it is a clean flop output
    // that always equals (div_cnt >= CLK_DIV/2).
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            vga_clk <= (div_next >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA timing generator and registered DAC colour stage
//
// Ports:
//   clk          in   50 MHz system clock
//   rst          in   synchronous active-low reset
//   pixel_color  in   {R,G,B} returned for the current (next_x,next_y)
//   next_x/y     out  coordinate presented on the pins at the next pixel strobe
//   vga_clk      out  pixel clock to the DAC
//   vga_hs/vs    out  active-low syncs
//   vga_blank_n  out  high during active video
//   vga_sync_n   out  tied low
//   vga_r/g/b    out  DAC colour, zero outside active video
//   frame_start  out  one-clk pulse when pixel (0,0) is presented
module vga_scan_driver #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CLK_DIV  = vga_pkg::CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_color,
    output logic [31:0] next_x,
    output logic [31:0] next_y,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    import vga_pkg::*;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] ny;
    logic             hs_on;
    logic             vs_on;
    logic             active;
    rgb_t             color_in;
    rgb_t             rgb;

    pixel_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .vga_clk (vga_clk)
    );

    // The upcoming pixel is always the raster successor of the one on the
    // pins. Reset parks h_cnt/v_cnt on the last pixel of the frame, so the
    // successor (and therefore the first strobe after release) is (0,0).
    always_comb begin
        nx = h_cnt + 1'b1;
        ny = v_cnt;
        if (h_cnt == X_LAST) begin
            nx = '0;
            ny = (v_cnt == Y_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    always_comb begin
        hs_on    = (nx >= HS_START) && (nx < HS_END);
        vs_on    = (ny >= VS_START) && (ny < VS_END);
        active   = (nx < X_ACT) && (ny < Y_ACT);
        color_in = pixel_color;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt       <= X_LAST;
            v_cnt       <= Y_LAST;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= nx;
                v_cnt       <= ny;
                vga_hs      <= ~hs_on;
                vga_vs      <= ~vs_on;
                vga_blank_n <= active;
                // Blanking coordinates still reach the interpreter; whatever
                // it returns there is discarded.
                rgb         <= active ? color_in : '0;
                frame_start <= (nx == '0) && (ny == '0);
            end
        end
    end

    assign next_x     = {{(32 - CNT_W){1'b0}}, nx};
    assign next_y     = {{(32 - CNT_W){1'b0}}, ny};
    assign vga_sync_n = 1'b0;
    assign vga_r      = rgb.r;
    assign vga_g      = rgb.g;
    assign vga_b      = rgb.b;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - randomized self-checking bench for vga_scan_driver
module tb_vga_scan_driver;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
    localparam int CD = 2;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 12
    localparam int NPIX = HT * VT;           // 300 pixels, 600 clks per frame

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] pixel_color = 24'h0;
    logic [31:0] next_x, next_y;
    logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_scan_driver #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (CD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_color (pixel_color),
        .next_x      (next_x),
        .next_y      (next_y),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Random colour every clk; the DUT samples whatever is current at its edge.
    always @(negedge clk) pixel_color = 24'($urandom);

    // Reference model: pixel index follows from clk edges since release.
    int          e = 0;
    int          n, p, x, y, q;
    logic [23:0] m_rgb = 24'h0;
    logic        m_hs = 1'b1, m_vs = 1'b1, m_bl = 1'b0, m_fs = 1'b0;
    int          m_nx = 0, m_ny = 0;

    int   cyc = 0;
    int   last_fs = -1;
    bit   first_fs = 1'b1;
    bit   prev_ok = 1'b0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_bl = 1'b0;
    int   hs_falls = 0, vs_falls = 0, periods = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            e = 0;
            m_rgb = 24'h0; m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0; m_fs = 1'b0;
            m_nx = 0; m_ny = 0;
            last_fs = -1;
            first_fs = 1'b1;
        end else begin
            e++;
            m_fs = 1'b0;
            if (e % CD == 0) begin
                n = e / CD - 1;
                p = n % NPIX;
                x = p % HT;
                y = p / HT;
                m_hs = !(x >= HA + HF && x < HA + HF + HS);
                m_vs = !(y >= VA + VF && y < VA + VF + VS);
                m_bl = (x < HA) && (y < VA);
                m_rgb = m_bl ? pixel_color : 24'h0;
                m_fs = (p == 0);
                q = (p + 1) % NPIX;
                m_nx = q % HT;
                m_ny = q / HT;
            end
        end

        check("next_x", next_x, 32'(m_nx));
        check("next_y", next_y, 32'(m_ny));
        check("vga_hs", 32'(vga_hs), 32'(m_hs));
        check("vga_vs", 32'(vga_vs), 32'(m_vs));
        check("vga_blank_n", 32'(vga_blank_n), 32'(m_bl));
        check("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, m_rgb});
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("vga_clk", 32'(vga_clk), 32'(rst && ((e % CD) >= CD / 2)));
        check("vga_sync_n", 32'(vga_sync_n), 32'd0);

        // Hand-computed raster landmarks for the reduced timing.
        if (rst && prev_ok) begin
            if (prev_hs && !vga_hs) begin
                hs_falls++;
                check("hs_fall_next_x", next_x, 32'd19);
            end
            if (!prev_hs && vga_hs) check("hs_rise_next_x", next_x, 32'd22);
            if (prev_bl && !vga_blank_n) check("blank_end_next_x", next_x, 32'd17);
            if (prev_vs && !vga_vs) begin
                vs_falls++;
                check("vs_fall_next_xy", {next_y[15:0], next_x[15:0]}, {16'd7, 16'd1});
            end
        end
        if (rst && frame_start) begin
            check("fs_next_xy", {next_y[15:0], next_x[15:0]}, {16'd0, 16'd1});
            if (first_fs) begin
                check("fs_first_latency", 32'(e), 32'd2);
            end else begin
                check("fs_period_clks", 32'(cyc - last_fs), 32'd600);
                periods++;
            end
            first_fs = 1'b0;
            last_fs = cyc;
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        prev_bl = vga_blank_n;
        prev_ok = rst;
    end

    initial begin
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (1300) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rst = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(50, 900)) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (1250) @(negedge clk);

        check("hs_falls_seen", 32'(hs_falls > 0), 32'd1);
        check("vs_falls_seen", 32'(vs_falls > 0), 32'd1);
        check("fs_periods_seen", 32'(periods > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
